hack_trace_recorder: RTL and testbench

Parametrised, synthesizable trace recorder for the Hack computer. It captures the per-cycle CPU state (PC, A, D, M, instruction) into a circular buffer and freezes capture a programmable number of samples after a trigger. The trigger is a PC match or an external mismatch flag from a lockstep model comparison. The captured window is then streamed out oldest-first over a valid/ready port. It sits beside `Computer` in both simulation and FPGA builds, replacing `$monitor`-style logging with on-chip capture.

---
 rtl/hack_trace_recorder.sv | 196 +++++++++++++++++++
 tb/tb_hack_trace_recorder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_trace_recorder.sv
// ============================================================================
// Module   : hack_trace_recorder
// Purpose  : Circular-buffer trace capture of Hack CPU state with PC/external
//            trigger, post-trigger window and oldest-first valid/ready dump.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_trace_recorder #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 cap_en,
    input  logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     a_reg,
    input  logic [WIDTH-1:0]     d_reg,
    input  logic [WIDTH-1:0]     m_reg,
    input  logic [WIDTH-1:0]     instr,
    input  logic                 trig_pc_en,
    input  logic [WIDTH-1:0]     trig_pc,
    input  logic                 trig_ext,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [5*WIDTH-1:0]   rd_data,
    output logic                 rd_trig,
    output logic                 rd_last,
    output logic                 armed,
    output logic                 triggered,
    output logic                 done
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_RW = 5 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DUMP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_RW-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_trig_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_PW-1:0]    r_post_cnt;
    logic [c_CW-1:0]    r_count;
    logic [c_CW-1:0]    r_issue_left;
    logic [c_RW-1:0]    r_q;
    logic               r_q_vld;
    logic               r_q_trig;
    logic               r_q_last;

    logic               w_capturing;
    logic               w_we;
    logic               w_trig;
    logic [c_PW-1:0]    w_wr_ptr_nxt;
    logic [c_CW-1:0]    w_count_nxt;
    logic [c_PW-1:0]    w_dump_start;
    logic               w_out_load;
    logic               w_issue;

    assign w_capturing  = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_we         = w_capturing && cap_en && !abort;
    assign w_trig       = cap_en && ((trig_pc_en && (pc == trig_pc)) || trig_ext);
    assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
    assign w_count_nxt  = (r_count == c_CW'(DEPTH)) ? r_count : r_count + 1'b1;
    assign w_dump_start = w_wr_ptr_nxt - w_count_nxt[c_PW-1:0];

    // Stage 1 (RAM read register) acts as the skid: it refills whenever the
    // output register can take its current contents, so no bubbles appear.
    assign w_out_load   = !rd_valid || rd_ready;
    assign w_issue      = (r_state == S_DUMP) && (r_issue_left != '0) &&
                          (!r_q_vld || w_out_load);

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= {pc, a_reg, d_reg, m_reg, instr};
        end
        if (w_issue) begin
            r_q <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_trig_ptr   <= '0;
            r_rd_ptr     <= '0;
            r_post_cnt   <= '0;
            r_count      <= '0;
            r_issue_left <= '0;
            r_q_vld      <= 1'b0;
            r_q_trig     <= 1'b0;
            r_q_last     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_trig      <= 1'b0;
            rd_last      <= 1'b0;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            r_state      <= S_IDLE;
            r_issue_left <= '0;
            r_q_vld      <= 1'b0;
            rd_valid     <= 1'b0;
            rd_trig      <= 1'b0;
            rd_last      <= 1'b0;
            armed        <= 1'b0;
            triggered    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                        done     <= 1'b0;
                        armed    <= 1'b1;
                        r_state  <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (cap_en) begin
                        r_wr_ptr <= w_wr_ptr_nxt;
                        r_count  <= w_count_nxt;
                        if (w_trig) begin
                            r_trig_ptr <= r_wr_ptr;
                            triggered  <= 1'b1;
                            armed      <= 1'b0;
                            if (POST_TRIG == 0) begin
                                r_rd_ptr     <= w_dump_start;
                                r_issue_left <= w_count_nxt;
                                r_state      <= S_DUMP;
                            end else begin
                                r_post_cnt <= c_PW'(POST_TRIG);
                                r_state    <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (cap_en) begin
                        r_wr_ptr   <= w_wr_ptr_nxt;
                        r_count    <= w_count_nxt;
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == c_PW'(1)) begin
                            r_rd_ptr     <= w_dump_start;
                            r_issue_left <= w_count_nxt;
                            r_state      <= S_DUMP;
                        end
                    end
                end
                S_DUMP: begin
                    if (w_issue) begin
                        r_rd_ptr     <= r_rd_ptr + 1'b1;
                        r_issue_left <= r_issue_left - 1'b1;
                        r_q_vld      <= 1'b1;
                        r_q_trig     <= (r_rd_ptr == r_trig_ptr);
                        r_q_last     <= (r_issue_left == c_CW'(1));
                    end else if (r_q_vld && w_out_load) begin
                        r_q_vld <= 1'b0;
                    end

                    if (rd_valid && rd_ready && rd_last) begin
                        rd_valid  <= 1'b0;
                        rd_trig   <= 1'b0;
                        rd_last   <= 1'b0;
                        done      <= 1'b1;
                        triggered <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_out_load) begin
                        rd_valid <= r_q_vld;
                        if (r_q_vld) begin
                            rd_data <= r_q;
                            rd_trig <= r_q_trig;
                            rd_last <= r_q_last;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hack_trace_recorder.sv
// ============================================================================
// Module   : tb_hack_trace_recorder
// Purpose  : Scoreboard bench for hack_trace_recorder (DEPTH=8, POST_TRIG=3).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hack_trace_recorder;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int PT = 3;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_POST  = 2;
    localparam int M_DUMP  = 3;

    logic           clk        = 1'b0;
    logic           reset_n    = 1'b1;
    logic           arm        = 1'b0;
    logic           abort      = 1'b0;
    logic           cap_en     = 1'b0;
    logic [W-1:0]   pc         = '0;
    logic [W-1:0]   a_reg      = '0;
    logic [W-1:0]   d_reg      = '0;
    logic [W-1:0]   m_reg      = '0;
    logic [W-1:0]   instr      = '0;
    logic           trig_pc_en = 1'b0;
    logic [W-1:0]   trig_pc    = '0;
    logic           trig_ext   = 1'b0;
    logic           rd_ready   = 1'b1;
    logic           rd_valid;
    logic [5*W-1:0] rd_data;
    logic           rd_trig;
    logic           rd_last;
    logic           armed;
    logic           triggered;
    logic           done;

    typedef struct {
        logic [5*W-1:0] data;
        bit             trig;
        bit             last;
    } exp_t;

    typedef struct {
        logic [W-1:0] p;
        bit           t;
    } hist_t;

    exp_t  exp_q[$];
    hist_t hist[$];
    int    mstate    = M_IDLE;
    int    post_left = 0;
    int    n_chk     = 0;
    int    n_err     = 0;
    bit    bp_mode   = 1'b0;

    hack_trace_recorder #(.WIDTH(W), .DEPTH(D), .POST_TRIG(PT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .arm        (arm),
        .abort      (abort),
        .cap_en     (cap_en),
        .pc         (pc),
        .a_reg      (a_reg),
        .d_reg      (d_reg),
        .m_reg      (m_reg),
        .instr      (instr),
        .trig_pc_en (trig_pc_en),
        .trig_pc    (trig_pc),
        .trig_ext   (trig_ext),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_trig    (rd_trig),
        .rd_last    (rd_last),
        .armed      (armed),
        .triggered  (triggered),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5*W-1:0] rec(input logic [W-1:0] p);
        return {p, p ^ 16'hA5A5, p + 16'h0100, ~p, {p[7:0], p[15:8]}};
    endfunction

    task automatic push_hist(input logic [W-1:0] p, input bit t);
        hist_t h;
        h.p = p;
        h.t = t;
        hist.push_back(h);
        if (hist.size() > D) void'(hist.pop_front());
    endtask

    task automatic finish_capture();
        exp_t e;
        for (int i = 0; i < hist.size(); i++) begin
            e.data = rec(hist[i].p);
            e.trig = hist[i].t;
            e.last = (i == hist.size() - 1);
            exp_q.push_back(e);
        end
        mstate = M_DUMP;
    endtask

    // Drive one cycle of stimulus, advance the reference model, then step the clock.
    task automatic step(input bit s_arm, input bit s_abort, input bit en,
                        input logic [W-1:0] p, input bit ext);
        bit t;
        arm = s_arm; abort = s_abort; cap_en = en; trig_ext = ext;
        pc = p; a_reg = p ^ 16'hA5A5; d_reg = p + 16'h0100; m_reg = ~p;
        instr = {p[7:0], p[15:8]};
        t = en && ((trig_pc_en && (p == trig_pc)) || ext);
        if (s_abort) begin
            mstate = M_IDLE;
        end else begin
            case (mstate)
                M_IDLE: if (s_arm) begin
                    hist.delete();
                    mstate = M_ARMED;
                end
                M_ARMED: if (en) begin
                    push_hist(p, t);
                    if (t) begin
                        if (PT == 0) finish_capture();
                        else begin
                            post_left = PT;
                            mstate    = M_POST;
                        end
                    end
                end
                M_POST: if (en) begin
                    push_hist(p, 1'b0);
                    post_left--;
                    if (post_left == 0) finish_capture();
                end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_dump(input bit chk_lat, input int exp_span);
        int cyc   = 0;
        int first = -1;
        cap_en = 1'b0; trig_ext = 1'b0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            if (chk_lat && cyc <= 3) check_eq("first_valid_latency", rd_valid, (cyc == 3));
            if (rd_valid && first < 0) first = cyc;
        end
        if (cyc >= 200) check_eq("dump_timeout", exp_q.size(), 0);
        if (exp_span > 0) check_eq("back_to_back_span", cyc - first + 1, exp_span);
        @(posedge clk); #1;
        check_eq("done_after_dump", done, 1'b1);
        check_eq("trig_clr_after_dump", triggered, 1'b0);
        check_eq("valid_drop_after_dump", rd_valid, 1'b0);
        mstate = M_IDLE;
    endtask

    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_record", {rd_trig, rd_last, rd_data}, '0);
            end else begin
                check_eq("record", {rd_trig, rd_last, rd_data},
                         {exp_q[0].trig, exp_q[0].last, exp_q[0].data});
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            rd_ready = bp_mode ? ~rd_ready : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check_eq("reset_flags", {rd_valid, rd_trig, rd_last, armed, triggered, done}, '0);
        check_eq("reset_data", rd_data, '0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Ring-wrap dump with PC trigger, back-to-back
        trig_pc_en = 1'b1; trig_pc = 16'h000A;
        step(1, 0, 0, 16'h0, 0);
        check_eq("s1_armed", armed, 1'b1);
        for (int i = 0; i < 40 && mstate != M_DUMP; i++) step(0, 0, 1, 16'(i), 0);
        wait_dump(1, 8);

        // Early external trigger, short window
        trig_pc_en = 1'b0;
        step(1, 0, 0, 16'h0, 0);
        check_eq("s2_done_cleared", done, 1'b0);
        for (int i = 0; i < 40 && mstate != M_DUMP; i++) step(0, 0, 1, 16'(i), (i == 1));
        wait_dump(1, 5);

        // Qualified sampling
        trig_pc_en = 1'b1; trig_pc = 16'h0004;
        step(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 40 && mstate != M_DUMP; i++) step(0, 0, (i % 2 == 0), 16'(i), 0);
        wait_dump(1, 6);

        // Backpressure on the ring-wrap scenario
        trig_pc = 16'h000A;
        step(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 40 && mstate != M_DUMP; i++) step(0, 0, 1, 16'(i), 0);
        bp_mode = 1'b1;
        wait_dump(0, 0);
        bp_mode = 1'b0;

        // Trigger in arm cycle ignored; arm during POST ignored
        trig_pc_en = 1'b0;
        step(1, 0, 1, 16'h0050, 1);
        step(0, 0, 1, 16'h0000, 0);
        step(0, 0, 1, 16'h0001, 0);
        check_eq("s5_no_arm_cycle_trig", {armed, triggered}, 2'b10);
        step(0, 0, 1, 16'h0002, 1);
        step(1, 0, 1, 16'h0003, 0);
        check_eq("s5_post_arm_ignored", {armed, triggered}, 2'b01);
        for (int i = 4; i < 40 && mstate != M_DUMP; i++) step(0, 0, 1, 16'(i), 0);
        wait_dump(1, 6);

        // Abort mid-POST, abort in arm cycle, reset mid-DUMP
        trig_pc_en = 1'b1; trig_pc = 16'h0003;
        step(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'(i), 0);
        step(0, 1, 1, 16'h0005, 0);
        check_eq("s6_abort_flags", {armed, triggered, done, rd_valid}, '0);
        for (int i = 6; i < 14; i++) step(0, 0, 1, 16'(i), 0);
        check_eq("s6_abort_no_dump", rd_valid, 1'b0);
        step(1, 1, 0, 16'h0, 0);
        check_eq("s6_abort_in_arm_cycle", armed, 1'b0);
        step(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 40 && mstate != M_DUMP; i++) step(0, 0, 1, 16'(i), 0);
        cap_en = 1'b0;
        for (int i = 0; i < 20 && !rd_valid; i++) begin
            @(negedge clk); #1;
        end
        check_eq("s6_dump_started", rd_valid, 1'b1);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_eq("s6_async_reset_flags", {rd_valid, rd_trig, rd_last, armed, triggered, done}, '0);
        check_eq("s6_async_reset_data", rd_data, '0);
        exp_q.delete();
        mstate = M_IDLE;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        check_eq("s6_idle_after_reset", {rd_valid, armed, triggered, done}, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
